// File: rtl/mips_exec_pkg.sv
// Shared encodings for the MIPS execute-stage core.
// Opcodes, functs, ALU op codes, writeback select, ALU source select.
package mips_exec_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_GPIO  = 6'h1F;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;
  localparam logic [5:0] FN_GIN   = 6'h00;
  localparam logic [5:0] FN_GOUT  = 6'h01;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_NOR   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_ADD   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0101;
  localparam logic [3:0] ALU_MULT  = 4'b0110;
  localparam logic [3:0] ALU_MULTU = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_SRL   = 4'b1001;
  localparam logic [3:0] ALU_SRA   = 4'b1010;
  localparam logic [3:0] ALU_SLT   = 4'b1100;
  localparam logic [3:0] ALU_SLTU  = 4'b1101;
  localparam logic [3:0] ALU_NONE  = 4'b1111;

  localparam logic [1:0] WB_RESULT = 2'b00;
  localparam logic [1:0] WB_HI     = 2'b01;
  localparam logic [1:0] WB_LO     = 2'b10;

  typedef enum logic [1:0] {
    SRC_RT,
    SRC_SEXT,
    SRC_ZEXT
  } alu_src_e;

endpackage

// File: rtl/mips_exec_alu.sv
// Combinational ALU: logic, add/sub, shifts, compares, 32x32 multiply.
// Shifts act on b; hi_word is the upper product word for mult/multu.
module mips_exec_alu
  import mips_exec_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  input  logic [3:0]  op,
  output logic [31:0] result,
  output logic [31:0] hi_word,
  output logic        zero
);

  logic [7:0]  sh;
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign sh = {3'b000, shamt};

  // Sign-extending to 64 bits makes the truncated product signed-correct
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'b0, a} * {32'b0, b};

  always_comb begin
    result  = '0;
    hi_word = '0;
    case (op)
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_NOR:   result = ~(a | b);
      ALU_XOR:   result = a ^ b;
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_MULT: begin
        result  = prod_s[31:0];
        hi_word = prod_s[63:32];
      end
      ALU_MULTU: begin
        result  = prod_u[31:0];
        hi_word = prod_u[63:32];
      end
      ALU_SLL:   result = b << sh;
      ALU_SRL:   result = b >> sh;
      ALU_SRA:   result = $signed(b) >>> sh;
      ALU_SLT:   result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU:  result = {31'b0, a < b};
      default:   result = '0;
    endcase
  end

  assign zero = (result == 32'b0);

endmodule

// File: rtl/mips_exec_unit.sv
// MIPS execute-stage core: decoder, 32x32 register file, ALU, HI/LO.
// Define MIPS_EXEC_MULT_EN to enable mult/multu and the HI/LO registers.
module mips_exec_unit
  import mips_exec_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] result,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        zero,
  output logic        regwrite,
  output logic [4:0]  dest_addr,
  output logic [1:0]  wb_sel,
  output logic        gpio_in_en,
  output logic        gpio_out_en
);

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];

  logic [31:0] regs [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_we && wb_addr != 5'd0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  assign rs_data = (rs == 5'd0) ? 32'b0 : regs[rs];
  assign rt_data = (rt == 5'd0) ? 32'b0 : regs[rt];

  logic [3:0] alu_op;
  alu_src_e   alu_src;
  logic       is_lui;
`ifdef MIPS_EXEC_MULT_EN
  logic       is_mult;
`endif

  always_comb begin
    alu_op      = ALU_NONE;
    alu_src     = SRC_RT;
    is_lui      = 1'b0;
    regwrite    = 1'b0;
    wb_sel      = WB_RESULT;
    gpio_in_en  = 1'b0;
    gpio_out_en = 1'b0;
`ifdef MIPS_EXEC_MULT_EN
    is_mult     = 1'b0;
`endif
    unique case (1'b1)
      (opcode == OP_RTYPE): begin
        unique case (1'b1)
          (funct == FN_ADD || funct == FN_ADDU): begin
            alu_op = ALU_ADD; regwrite = 1'b1;
          end
          (funct == FN_SUB || funct == FN_SUBU): begin
            alu_op = ALU_SUB; regwrite = 1'b1;
          end
          (funct == FN_AND): begin
            alu_op = ALU_AND; regwrite = 1'b1;
          end
          (funct == FN_OR): begin
            alu_op = ALU_OR; regwrite = 1'b1;
          end
          (funct == FN_XOR): begin
            alu_op = ALU_XOR; regwrite = 1'b1;
          end
          (funct == FN_NOR): begin
            alu_op = ALU_NOR; regwrite = 1'b1;
          end
          (funct == FN_SLT): begin
            alu_op = ALU_SLT; regwrite = 1'b1;
          end
          (funct == FN_SLTU): begin
            alu_op = ALU_SLTU; regwrite = 1'b1;
          end
          (funct == FN_SLL): begin
            alu_op = ALU_SLL; regwrite = 1'b1;
          end
          (funct == FN_SRL): begin
            alu_op = ALU_SRL; regwrite = 1'b1;
          end
          (funct == FN_SRA): begin
            alu_op = ALU_SRA; regwrite = 1'b1;
          end
`ifdef MIPS_EXEC_MULT_EN
          (funct == FN_MULT): begin
            alu_op = ALU_MULT; is_mult = 1'b1;
          end
          (funct == FN_MULTU): begin
            alu_op = ALU_MULTU; is_mult = 1'b1;
          end
`endif
          (funct == FN_MFHI): begin
            regwrite = 1'b1; wb_sel = WB_HI;
          end
          (funct == FN_MFLO): begin
            regwrite = 1'b1; wb_sel = WB_LO;
          end
          default: ;
        endcase
      end
      (opcode == OP_ADDI || opcode == OP_ADDIU): begin
        alu_op = ALU_ADD; alu_src = SRC_SEXT; regwrite = 1'b1;
      end
      (opcode == OP_SLTI): begin
        alu_op = ALU_SLT; alu_src = SRC_SEXT; regwrite = 1'b1;
      end
      (opcode == OP_SLTIU): begin
        alu_op = ALU_SLTU; alu_src = SRC_SEXT; regwrite = 1'b1;
      end
      (opcode == OP_ANDI): begin
        alu_op = ALU_AND; alu_src = SRC_ZEXT; regwrite = 1'b1;
      end
      (opcode == OP_ORI): begin
        alu_op = ALU_OR; alu_src = SRC_ZEXT; regwrite = 1'b1;
      end
      (opcode == OP_XORI): begin
        alu_op = ALU_XOR; alu_src = SRC_ZEXT; regwrite = 1'b1;
      end
      (opcode == OP_LUI): begin
        alu_op = ALU_SLL; alu_src = SRC_ZEXT;
        is_lui = 1'b1; regwrite = 1'b1;
      end
      (opcode == OP_GPIO): begin
        unique case (1'b1)
          (funct == FN_GIN): begin
            regwrite = 1'b1; gpio_in_en = 1'b1;
          end
          (funct == FN_GOUT): gpio_out_en = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign dest_addr = (opcode == OP_RTYPE) ? rd : rt;

  logic [31:0] alu_b;
  logic [4:0]  alu_sh;
  logic [31:0] alu_hi;

  always_comb begin
    case (alu_src)
      SRC_SEXT: alu_b = {{16{imm[15]}}, imm};
      SRC_ZEXT: alu_b = {16'b0, imm};
      default:  alu_b = rt_data;
    endcase
  end

  // lui is a fixed 16-bit left shift of the zero-extended immediate
  assign alu_sh = is_lui ? 5'd16 : shamt;

  mips_exec_alu u_alu (
    .a       (rs_data),
    .b       (alu_b),
    .shamt   (alu_sh),
    .op      (alu_op),
    .result  (result),
    .hi_word (alu_hi),
    .zero    (zero)
  );

`ifdef MIPS_EXEC_MULT_EN
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (is_mult) begin
      hi_q <= alu_hi;
      lo_q <= result;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;
`else
  logic [31:0] unused_hi;
  assign unused_hi = alu_hi;
  assign hi = '0;
  assign lo = '0;
`endif

endmodule

// File: tb/tb_mips_exec_unit.sv
// Directed self-checking bench for mips_exec_unit.
// Follows MIPS_EXEC_MULT_EN for HI/LO expectations.
module tb_mips_exec_unit;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] result;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        zero;
  logic        regwrite;
  logic [4:0]  dest_addr;
  logic [1:0]  wb_sel;
  logic        gpio_in_en;
  logic        gpio_out_en;

  int passed;
  int total;

  mips_exec_unit dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .result      (result),
    .hi          (hi),
    .lo          (lo),
    .zero        (zero),
    .regwrite    (regwrite),
    .dest_addr   (dest_addr),
    .wb_sel      (wb_sel),
    .gpio_in_en  (gpio_in_en),
    .gpio_out_en (gpio_out_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(
    input logic [4:0] s, input logic [4:0] t,
    input logic [4:0] d, input logic [4:0] sa,
    input logic [5:0] fn);
    return {6'h00, s, t, d, sa, fn};
  endfunction

  function automatic logic [31:0] itype(
    input logic [5:0] op, input logic [4:0] s,
    input logic [4:0] t, input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      passed++;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    wb_we = 1'b1; wb_addr = a; wb_data = d;
    @(posedge clk); #1;
    wb_we = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    for (int i = 0; i < 32; i++) begin
      instr = rtype(i[4:0], i[4:0], 5'd0, 5'd0, 6'h3F);
      #1;
      v = rs_data | rt_data;
      total++;
      if (v !== 32'b0)
        $display("FAIL reset_reg%0d: got %h expected 0", i, v);
      else
        passed++;
    end
    instr = 32'b0;
    #1;
    total++;
    if (result !== 32'b0 || zero !== 1'b1 || hi !== 0 || lo !== 0)
      $display("FAIL reset_out: res %h zero %b hi %h lo %h expected 0 1 0 0",
               result, zero, hi, lo);
    else
      passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_regfile;
    wr(5'd5, 32'h1234);
    instr = rtype(5'd5, 5'd0, 5'd0, 5'd0, 6'h3F);
    #1;
    chk("rf_r5", rs_data, 32'h00001234);
    wr(5'd0, 32'hDEAD_BEEF);
    instr = rtype(5'd0, 5'd0, 5'd0, 5'd0, 6'h3F);
    #1;
    chk("rf_r0", rs_data, 32'h0);
    @(posedge clk); #1;
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h5555;
    instr = rtype(5'd5, 5'd0, 5'd0, 5'd0, 6'h3F);
    #1;
    chk("rf_nobypass", rs_data, 32'h1234);
    @(posedge clk); #1;
    wb_we = 1'b0;
    chk("rf_after", rs_data, 32'h5555);
  endtask

  task automatic test_back_to_back;
    @(posedge clk); #1;
    wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'hA5A5_0008;
    @(posedge clk); #1;
    wb_addr = 5'd9; wb_data = 32'h5A5A_0009;
    @(posedge clk); #1;
    wb_we = 1'b0;
    instr = rtype(5'd8, 5'd9, 5'd0, 5'd0, 6'h3F);
    #1;
    chk("b2b_r8", rs_data, 32'hA5A5_0008);
    chk("b2b_r9", rt_data, 32'h5A5A_0009);
  endtask

  task automatic test_add_sub;
    wr(5'd1, 32'd7);
    wr(5'd2, 32'd9);
    instr = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    #1;
    chk("add_res", result, 32'h10);
    chk("add_rw", {31'b0, regwrite}, 32'd1);
    chk("add_dest", {27'b0, dest_addr}, 32'd3);
    chk("add_wbsel", {30'b0, wb_sel}, 32'd0);
    instr = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h22);
    #1;
    chk("sub_res", result, 32'hFFFF_FFFE);
    chk("sub_zero", {31'b0, zero}, 32'd0);
    instr = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h27);
    #1;
    chk("nor_res", result, 32'hFFFF_FFF0);
  endtask

  task automatic test_imm;
    wr(5'd1, 32'd1);
    instr = itype(6'h08, 5'd1, 5'd4, 16'hFFFF);
    #1;
    chk("addi_res", result, 32'h0);
    chk("addi_zero", {31'b0, zero}, 32'd1);
    chk("addi_dest", {27'b0, dest_addr}, 32'd4);
    instr = itype(6'h0C, 5'd1, 5'd4, 16'hFFFF);
    #1;
    chk("andi_res", result, 32'h1);
    instr = itype(6'h0F, 5'd0, 5'd4, 16'hABCD);
    #1;
    chk("lui_res", result, 32'hABCD_0000);
    instr = itype(6'h0B, 5'd1, 5'd4, 16'hFFFF);
    #1;
    chk("sltiu_res", result, 32'h1);
  endtask

  task automatic test_shift_slt;
    wr(5'd2, 32'h8000_0000);
    instr = rtype(5'd0, 5'd2, 5'd3, 5'd4, 6'h03);
    #1;
    chk("sra_res", result, 32'hF800_0000);
    instr = rtype(5'd0, 5'd2, 5'd3, 5'd4, 6'h02);
    #1;
    chk("srl_res", result, 32'h0800_0000);
    wr(5'd1, 32'hFFFF_FFFF);
    wr(5'd2, 32'd1);
    instr = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h2A);
    #1;
    chk("slt_res", result, 32'h1);
    instr = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h2B);
    #1;
    chk("sltu_res", result, 32'h0);
  endtask

  task automatic test_mult;
    wr(5'd2, 32'd2);
    @(posedge clk); #1;
    instr = rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h18);
    #1;
    chk("mult_rw", {31'b0, regwrite}, 32'd0);
`ifdef MIPS_EXEC_MULT_EN
    chk("mult_lo_comb", result, 32'hFFFF_FFFE);
`endif
    @(posedge clk); #1;
    instr = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
`ifdef MIPS_EXEC_MULT_EN
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);
`else
    chk("mult_hi", hi, 32'h0);
    chk("mult_lo", lo, 32'h0);
`endif
    @(posedge clk); #1;
`ifdef MIPS_EXEC_MULT_EN
    chk("hold_hi", hi, 32'hFFFF_FFFF);
`else
    chk("hold_hi", hi, 32'h0);
`endif
    instr = rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h19);
    @(posedge clk); #1;
    instr = rtype(5'd0, 5'd0, 5'd3, 5'd0, 6'h10);
    #1;
`ifdef MIPS_EXEC_MULT_EN
    chk("multu_hi", hi, 32'h1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);
`else
    chk("multu_hi", hi, 32'h0);
    chk("multu_lo", lo, 32'h0);
`endif
    chk("mfhi_wbsel", {30'b0, wb_sel}, 32'd1);
    chk("mfhi_rw", {31'b0, regwrite}, 32'd1);
    instr = rtype(5'd0, 5'd0, 5'd3, 5'd0, 6'h12);
    #1;
    chk("mflo_wbsel", {30'b0, wb_sel}, 32'd2);
  endtask

  task automatic test_gpio_undef;
    instr = {6'h1F, 5'd1, 5'd7, 10'd0, 6'h00};
    #1;
    chk("gin_en", {31'b0, gpio_in_en}, 32'd1);
    chk("gin_rw", {31'b0, regwrite}, 32'd1);
    chk("gin_dest", {27'b0, dest_addr}, 32'd7);
    chk("gin_out", {31'b0, gpio_out_en}, 32'd0);
    instr = {6'h1F, 5'd1, 5'd2, 10'd0, 6'h01};
    #1;
    chk("gout_en", {31'b0, gpio_out_en}, 32'd1);
    chk("gout_rw", {31'b0, regwrite}, 32'd0);
    chk("gout_rt", rt_data, 32'd2);
    instr = itype(6'h3A, 5'd1, 5'd2, 16'h1234);
    #1;
    chk("undef_op", {28'b0, regwrite, gpio_in_en, gpio_out_en,
                     |wb_sel}, 32'd0);
    chk("undef_res", result, 32'd0);
    instr = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F);
    #1;
    chk("undef_fn", {28'b0, regwrite, gpio_in_en, gpio_out_en,
                     |wb_sel}, 32'd0);
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    wb_we = 1'b1; wb_addr = 5'd6; wb_data = 32'h77;
    instr = rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h18);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    wb_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    instr = rtype(5'd6, 5'd1, 5'd0, 5'd0, 6'h3F);
    #1;
    chk("rstmid_r6", rs_data, 32'h0);
    chk("rstmid_r1", rt_data, 32'h0);
    chk("rstmid_hi", hi, 32'h0);
    chk("rstmid_lo", lo, 32'h0);
  endtask

  initial begin
    passed = 0;
    total = 0;
    rst = 1'b1;
    instr = 32'b0;
    wb_we = 1'b0;
    wb_addr = 5'd0;
    wb_data = 32'b0;
    #2;
    test_reset;
    test_regfile;
    test_back_to_back;
    test_add_sub;
    test_imm;
    test_shift_slt;
    test_mult;
    test_gpio_undef;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
